// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C memory-backed responder.
package i2c_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ACK_A,
      WDATA,
      ACK_D,
      RDATA,
      RACK,
      WAIT_STOP
   } i2c_slv_state_e;

   localparam int   I2C_ADDR_W  = 7;
   localparam int   I2C_DATA_W  = 8;
   localparam logic I2C_RW_READ = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings asynchronous SCL/SDA into the clk domain and flags bus edges and START/STOP.
module i2c_bus_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic scl_i,
   input  logic sda_i,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det,
   output logic sda_s
);

   logic [SYNC_STAGES-1:0] scl_p0, sda_p0;
   logic                   scl_p1, sda_p1;
   logic                   scl_s;

   // Idle bus is high on both lines, so preset to 1 to avoid phantom edges out of reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_p0 <= '1;
         sda_p0 <= '1;
         scl_p1 <= 1'b1;
         sda_p1 <= 1'b1;
      end else begin
         scl_p0 <= {scl_p0[SYNC_STAGES-2:0], scl_i};
         sda_p0 <= {sda_p0[SYNC_STAGES-2:0], sda_i};
         scl_p1 <= scl_s;
         sda_p1 <= sda_s;
      end
   end

   assign scl_s     = scl_p0[SYNC_STAGES-1];
   assign sda_s     = sda_p0[SYNC_STAGES-1];
   assign scl_rise  = scl_s & ~scl_p1;
   assign scl_fall  = ~scl_s & scl_p1;
   assign start_det = scl_s & scl_p1 & sda_p1 & ~sda_s;
   assign stop_det  = scl_s & scl_p1 & ~sda_p1 & sda_s;

endmodule

// File: rtl/i2c_mem_slave.sv
// I2C responder: one address+R/W byte then one data byte, backed by a small register file.
module i2c_mem_slave
   import i2c_pkg::*;
#(
   parameter int ADDR_W      = I2C_ADDR_W,
   parameter int DATA_W      = I2C_DATA_W,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              scl_i,
   input  logic              sda_i,
   output logic              sda_oe,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] last_addr,
   output logic [DATA_W-1:0] last_data,
   output logic              last_rw
);

   logic scl_rise, scl_fall, start_det, stop_det, sda_s;

   i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk       (clk),
      .rst       (rst),
      .scl_i     (scl_i),
      .sda_i     (sda_i),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det),
      .sda_s     (sda_s)
   );

   i2c_slv_state_e    state, state_next;
   logic [2:0]        bit_cnt, cnt_next;
   logic [DATA_W-1:0] shreg, shreg_next, shift_in, rd_byte;
   logic [ADDR_W-1:0] addr_q, addr_next;
   logic              rw_q, rw_next, oe_q, oe_next, we, fin;
   logic [DATA_W-1:0] mem [2**ADDR_W];

   assign shift_in = {shreg[DATA_W-2:0], sda_s};
   assign rd_byte  = mem[addr_q];
   assign busy     = (state != IDLE);
   assign sda_oe   = oe_q & ~rst;

   always_comb begin
      state_next = state;
      cnt_next   = bit_cnt;
      shreg_next = shreg;
      addr_next  = addr_q;
      rw_next    = rw_q;
      oe_next    = oe_q;
      we         = 1'b0;
      fin        = 1'b0;
      // Bus conditions outrank any SCL edge seen in the same cycle.
      if (start_det) begin
         state_next = ADDR;
         cnt_next   = 3'd0;
         oe_next    = 1'b0;
      end else if (stop_det) begin
         state_next = IDLE;
         cnt_next   = 3'd0;
         oe_next    = 1'b0;
      end else begin
         case (state)
            IDLE: ;
            ADDR, WDATA: begin
               if (scl_rise) begin
                  shreg_next = shift_in;
                  cnt_next   = bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     if (state == ADDR) begin
                        addr_next  = ADDR_W'(shift_in[DATA_W-1:1]);
                        rw_next    = shift_in[0];
                        state_next = ACK_A;
                     end else begin
                        we         = 1'b1;
                        state_next = ACK_D;
                     end
                  end
               end
            end
            // oe_q marks whether the ACK low has already been presented this phase.
            ACK_A: begin
               if (scl_fall) begin
                  if (!oe_q) begin
                     oe_next = 1'b1;
                  end else if (rw_q == I2C_RW_READ) begin
                     oe_next    = ~rd_byte[DATA_W-1];
                     shreg_next = {rd_byte[DATA_W-2:0], 1'b0};
                     cnt_next   = 3'd0;
                     state_next = RDATA;
                  end else begin
                     oe_next    = 1'b0;
                     cnt_next   = 3'd0;
                     state_next = WDATA;
                  end
               end
            end
            ACK_D: begin
               if (scl_fall) begin
                  oe_next = ~oe_q;
                  if (oe_q) state_next = WAIT_STOP;
               end
            end
            RDATA: begin
               if (scl_fall) begin
                  if (bit_cnt == 3'd7) begin
                     oe_next    = 1'b0;
                     cnt_next   = 3'd0;
                     state_next = RACK;
                  end else begin
                     oe_next    = ~shreg[DATA_W-1];
                     shreg_next = {shreg[DATA_W-2:0], 1'b0};
                     cnt_next   = bit_cnt + 3'd1;
                  end
               end
            end
            RACK: begin
               if (scl_rise) begin
                  fin        = 1'b1;
                  state_next = WAIT_STOP;
               end
            end
            WAIT_STOP: oe_next = 1'b0;
            default:   state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         bit_cnt   <= 3'd0;
         shreg     <= '0;
         addr_q    <= '0;
         rw_q      <= 1'b0;
         oe_q      <= 1'b0;
         done      <= 1'b0;
         last_addr <= '0;
         last_data <= '0;
         last_rw   <= 1'b0;
         for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= '0;
      end else begin
         state   <= state_next;
         bit_cnt <= cnt_next;
         shreg   <= shreg_next;
         addr_q  <= addr_next;
         rw_q    <= rw_next;
         oe_q    <= oe_next;
         done    <= we | fin;
         if (we) mem[addr_q] <= shift_in;
         if (we || fin) begin
            last_addr <= addr_q;
            last_data <= we ? shift_in : rd_byte;
            last_rw   <= rw_q;
         end
      end
   end

endmodule

// File: tb/tb_i2c_mem_slave.sv
// Bench for i2c_mem_slave: bit-level I2C master model against an array-based memory reference.
module tb_i2c_mem_slave;

   logic       clk = 1'b0;
   logic       rst, scl, sda_m;
   logic       sda_bus, sda_oe, busy, done, last_rw;
   logic [6:0] last_addr;
   logic [7:0] last_data;
   logic [7:0] ref_mem [128];
   int         vec, miss, done_cnt, idle_viol, busy_drop;
   logic       watch_busy;

   always #5 clk = ~clk;

   // Open-drain wire: low if either side pulls.
   assign sda_bus = sda_m & ~sda_oe;

   i2c_mem_slave dut (
      .clk       (clk),
      .rst       (rst),
      .scl_i     (scl),
      .sda_i     (sda_bus),
      .sda_oe    (sda_oe),
      .busy      (busy),
      .done      (done),
      .last_addr (last_addr),
      .last_data (last_data),
      .last_rw   (last_rw)
   );

   always @(negedge clk) begin
      if (done === 1'b1) done_cnt++;
      if (busy === 1'b0 && sda_oe === 1'b1) idle_viol++;
      if (watch_busy && busy !== 1'b1) busy_drop++;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_start();
      if (scl === 1'b0) begin
         tick(2); sda_m = 1'b1; tick(6); scl = 1'b1; tick(4);
      end else begin
         sda_m = 1'b1; tick(4);
      end
      sda_m = 1'b0; tick(4); scl = 1'b0;
   endtask

   task automatic bus_stop();
      tick(2); sda_m = 1'b0; tick(6); scl = 1'b1; tick(4); sda_m = 1'b1; tick(8);
   endtask

   task automatic bit_cycle(input logic b, output logic s);
      tick(2); sda_m = b; tick(6); scl = 1'b1; tick(4); s = sda_bus; tick(4); scl = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] d, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) bit_cycle(d[i], s);
      bit_cycle(1'b1, ack);
   endtask

   task automatic recv_byte(output logic [7:0] d);
      for (int i = 7; i >= 0; i--) bit_cycle(1'b1, d[i]);
   endtask

   task automatic do_write(input logic [6:0] a, input logic [7:0] d, output logic ka, output logic kd);
      bus_start(); send_byte({a, 1'b0}, ka); send_byte(d, kd); bus_stop();
   endtask

   task automatic do_read(input logic [6:0] a, input logic nack, output logic ka, output logic [7:0] d);
      logic s;
      bus_start(); send_byte({a, 1'b1}, ka); recv_byte(d); bit_cycle(nack, s); bus_stop();
   endtask

   task automatic test_reset();
      rst = 1'b1; tick(4); rst = 1'b0; tick(2);
      vec++; if (sda_oe !== 1'b0) begin miss++; $display("FAIL rst_sda_oe got %b want 0", sda_oe); end
      vec++; if (busy !== 1'b0) begin miss++; $display("FAIL rst_busy got %b want 0", busy); end
      vec++; if (done !== 1'b0) begin miss++; $display("FAIL rst_done got %b want 0", done); end
      vec++; if ({last_addr, last_data, last_rw} !== 16'h0) begin
         miss++; $display("FAIL rst_last got %h/%h/%b want 0/0/0", last_addr, last_data, last_rw);
      end
   endtask

   task automatic test_write();
      logic ka, kd; int d0;
      d0 = done_cnt;
      do_write(7'h15, 8'hA5, ka, kd);
      ref_mem[7'h15] = 8'hA5;
      vec++; if (ka !== 1'b0) begin miss++; $display("FAIL wr_ack_addr got %b want 0", ka); end
      vec++; if (kd !== 1'b0) begin miss++; $display("FAIL wr_ack_data got %b want 0", kd); end
      vec++; if (done_cnt - d0 != 1) begin miss++; $display("FAIL wr_done got %0d want 1", done_cnt - d0); end
      vec++; if (last_addr !== 7'h15) begin miss++; $display("FAIL wr_last_addr got %h want 15", last_addr); end
      vec++; if (last_data !== 8'hA5) begin miss++; $display("FAIL wr_last_data got %h want a5", last_data); end
      vec++; if (last_rw !== 1'b0) begin miss++; $display("FAIL wr_last_rw got %b want 0", last_rw); end
      vec++; if (busy !== 1'b0) begin miss++; $display("FAIL wr_busy_after_stop got %b want 0", busy); end
   endtask

   task automatic test_readback();
      logic ka; logic [7:0] d; int d0;
      d0 = done_cnt;
      do_read(7'h15, 1'b1, ka, d);
      vec++; if (ka !== 1'b0) begin miss++; $display("FAIL rd_ack_addr got %b want 0", ka); end
      vec++; if (d !== ref_mem[7'h15]) begin miss++; $display("FAIL rd_byte got %h want %h", d, ref_mem[7'h15]); end
      vec++; if (done_cnt - d0 != 1) begin miss++; $display("FAIL rd_done got %0d want 1", done_cnt - d0); end
      vec++; if (last_data !== ref_mem[7'h15]) begin miss++; $display("FAIL rd_last_data got %h want %h", last_data, ref_mem[7'h15]); end
      vec++; if (last_rw !== 1'b1) begin miss++; $display("FAIL rd_last_rw got %b want 1", last_rw); end
   endtask

   task automatic test_reset_read();
      logic ka; logic [7:0] d;
      rst = 1'b1; tick(1); rst = 1'b0;
      foreach (ref_mem[i]) ref_mem[i] = 8'h00;
      tick(2);
      do_read(7'h7F, 1'b1, ka, d);
      vec++; if (ka !== 1'b0) begin miss++; $display("FAIL rr_ack got %b want 0", ka); end
      vec++; if (d !== ref_mem[7'h7F]) begin miss++; $display("FAIL rr_byte got %h want %h", d, ref_mem[7'h7F]); end
   endtask

   task automatic test_abort_stop();
      logic ka, kd, s; logic [7:0] d; int d0;
      d = 8'($urandom_range(1, 255));
      do_write(7'h20, d, ka, kd);
      ref_mem[7'h20] = d;
      d0 = done_cnt;
      bus_start(); send_byte({7'h20, 1'b0}, ka);
      for (int i = 0; i < 4; i++) bit_cycle(~d[i], s);
      bus_stop();
      vec++; if (done_cnt != d0) begin miss++; $display("FAIL abort_done got %0d want 0", done_cnt - d0); end
      vec++; if (busy !== 1'b0) begin miss++; $display("FAIL abort_busy got %b want 0", busy); end
      vec++; if (sda_oe !== 1'b0) begin miss++; $display("FAIL abort_sda_oe got %b want 0", sda_oe); end
      do_read(7'h20, 1'b1, ka, d);
      vec++; if (d !== ref_mem[7'h20]) begin miss++; $display("FAIL abort_mem got %h want %h", d, ref_mem[7'h20]); end
   endtask

   task automatic test_rep_start();
      logic ka, kb, kc, kd; logic [6:0] a; logic [7:0] d, r;
      a = 7'($urandom_range(64, 127)); d = 8'($urandom);
      busy_drop = 0;
      bus_start(); send_byte({a, 1'b0}, ka);
      watch_busy = 1'b1;
      send_byte(d, kb);
      bus_start(); send_byte({7'h03, 1'b0}, kc); send_byte(8'h3C, kd);
      watch_busy = 1'b0;
      bus_stop();
      ref_mem[a] = d; ref_mem[7'h03] = 8'h3C;
      vec++; if ({ka, kb, kc, kd} !== 4'b0000) begin miss++; $display("FAIL rs_acks got %b want 0000", {ka, kb, kc, kd}); end
      vec++; if (busy_drop != 0) begin miss++; $display("FAIL rs_busy_held got %0d low cycles want 0", busy_drop); end
      do_read(7'h03, 1'b1, ka, r);
      vec++; if (r !== ref_mem[7'h03]) begin miss++; $display("FAIL rs_mem03 got %h want %h", r, ref_mem[7'h03]); end
      do_read(a, 1'b0, ka, r);
      vec++; if (r !== ref_mem[a]) begin miss++; $display("FAIL rs_mem_first got %h want %h", r, ref_mem[a]); end
   endtask

   task automatic test_random();
      logic ka, kd; logic [6:0] a; logic [7:0] d;
      for (int n = 0; n < 14; n++) begin
         a = 7'($urandom_range(0, 127));
         if (n < 4) a = 7'(n * 5 + 40);
         if (n < 5 || ($urandom % 2) == 0) begin
            d = 8'($urandom);
            do_write(a, d, ka, kd);
            ref_mem[a] = d;
            vec++; if ({ka, kd} !== 2'b00) begin miss++; $display("FAIL rnd_wr_ack a=%h got %b want 00", a, {ka, kd}); end
            vec++; if ({last_addr, last_data, last_rw} !== {a, d, 1'b0}) begin
               miss++; $display("FAIL rnd_wr_last got %h/%h/%b want %h/%h/0", last_addr, last_data, last_rw, a, d);
            end
         end else begin
            if (n % 3 == 0) a = 7'(40 + 5 * (n % 4));
            do_read(a, 1'($urandom % 2), ka, d);
            vec++; if (d !== ref_mem[a]) begin miss++; $display("FAIL rnd_rd a=%h got %h want %h", a, d, ref_mem[a]); end
            vec++; if ({last_addr, last_data, last_rw} !== {a, ref_mem[a], 1'b1}) begin
               miss++; $display("FAIL rnd_rd_last got %h/%h/%b want %h/%h/1", last_addr, last_data, last_rw, a, ref_mem[a]);
            end
         end
      end
   endtask

   task automatic test_rst_rdata();
      logic ka, kd; logic [7:0] d;
      d = 8'($urandom) & 8'h7F;
      do_write(7'h44, d, ka, kd);
      bus_start(); send_byte({7'h44, 1'b1}, ka);
      tick(6);
      vec++; if (sda_oe !== 1'b1) begin miss++; $display("FAIL rst_rdata_pre_oe got %b want 1", sda_oe); end
      rst = 1'b1; tick(1);
      vec++; if (sda_oe !== 1'b0) begin miss++; $display("FAIL rst_rdata_oe got %b want 0", sda_oe); end
      vec++; if (busy !== 1'b0) begin miss++; $display("FAIL rst_rdata_busy got %b want 0", busy); end
      rst = 1'b0;
      foreach (ref_mem[i]) ref_mem[i] = 8'h00;
      sda_m = 1'b1; tick(2); scl = 1'b1; tick(8);
      do_read(7'h44, 1'b1, ka, d);
      vec++; if (d !== ref_mem[7'h44]) begin miss++; $display("FAIL rst_rdata_mem got %h want %h", d, ref_mem[7'h44]); end
      vec++; if (idle_viol != 0) begin miss++; $display("FAIL idle_sda_oe got %0d cycles want 0", idle_viol); end
   endtask

   initial begin
      rst = 1'b1; scl = 1'b1; sda_m = 1'b1; watch_busy = 1'b0;
      vec = 0; miss = 0; done_cnt = 0; idle_viol = 0; busy_drop = 0;
      foreach (ref_mem[i]) ref_mem[i] = 8'h00;
      test_reset();
      test_write();
      test_readback();
      test_reset_read();
      test_abort_stop();
      test_rep_start();
      test_random();
      test_rst_rdata();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
